// File: rtl/seg_scan_n_if.sv
// Bundle of the display-scanner data/control signals between a driver and seg_scan_n.
// The slave modport is the scanner itself; the master modport is whatever feeds it.
interface seg_scan_n_if #(
  parameter int NDIG = 4
);
  localparam int SW = 4 + $clog2(NDIG);

  logic              en;
  logic              lzb;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   an;
  logic [6:0]        seg;
  logic [SW-1:0]     sum;
  logic              frame;

  modport master (output en, lzb, digits, input an, seg, sum, frame);
  modport slave  (input en, lzb, digits, output an, seg, sum, frame);
endinterface

// File: rtl/seg_scan_n.sv
// Multiplexed N-digit seven-segment scanner with dead time between slots,
// leading-zero blanking, scan enable and a registered digit sum.
module seg_scan_n #(
  parameter int NDIG = 4,
  parameter int DIV  = 50000,
  parameter int DEAD = 2
) (
  input logic          clk,
  input logic          reset,
  seg_scan_n_if.slave  bus
);
  localparam int SW   = 4 + $clog2(NDIG);
  localparam int IW   = $clog2(NDIG);
  localparam int CMAX = (DIV > DEAD) ? DIV : DEAD;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD > 0) ? DEAD - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

  typedef enum logic {ST_SCAN, ST_DEAD} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic [6:0]      snap;
  logic [NDIG-1:0] an_r;
  logic [6:0]      seg_r;
  logic            frame_r;
  logic [SW-1:0]   sum_r;

  logic [IW-1:0]   next_idx;
  logic [NDIG-1:0] an_cur;
  logic [NDIG-1:0] an_next;
  logic [NDIG-1:0] blank;
  logic            tail;
  logic [3:0]      nib;
  logic            nblank;
  logic [6:0]      slot_code;
  logic [SW-1:0]   total;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'h0: seg_code = 7'h01;
      4'h1: seg_code = 7'h4F;
      4'h2: seg_code = 7'h12;
      4'h3: seg_code = 7'h06;
      4'h4: seg_code = 7'h4C;
      4'h5: seg_code = 7'h24;
      4'h6: seg_code = 7'h20;
      4'h7: seg_code = 7'h0F;
      4'h8: seg_code = 7'h00;
      4'h9: seg_code = 7'h04;
      4'hA: seg_code = 7'h08;
      4'hB: seg_code = 7'h60;
      4'hC: seg_code = 7'h31;
      4'hD: seg_code = 7'h42;
      4'hE: seg_code = 7'h30;
      default: seg_code = 7'h38;
    endcase
  endfunction

  assign next_idx = (idx == IDX_LAST) ? '0 : idx + 1'b1;
  assign an_cur   = NDIG'(1) << idx;
  assign an_next  = NDIG'(1) << next_idx;

  // blank[i] is set when digit i and every more-significant digit are zero
  always_comb begin
    tail  = 1'b1;
    blank = '0;
    for (int unsigned k = 0; k < NDIG; k++) begin
      tail = tail & (bus.digits[4*(NDIG-1-k) +: 4] == 4'h0);
      blank[NDIG-1-k] = tail;
    end
    blank[0] = 1'b0;
  end

  always_comb begin
    nib    = '0;
    nblank = 1'b0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (IW'(i) == next_idx) begin
        nib    = bus.digits[4*i +: 4];
        nblank = bus.lzb & blank[i];
      end
    end
    slot_code = nblank ? 7'h7F : seg_code(nib);
  end

  always_comb begin
    total = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      total = total + SW'(bus.digits[4*i +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) sum_r <= '0;
    else        sum_r <= total;
  end

  // en low only blanks outputs; state, cnt, idx and snap are held so the slot resumes
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_DEAD;
      idx     <= IDX_LAST;
      cnt     <= '0;
      snap    <= '1;
      an_r    <= '0;
      seg_r   <= '1;
      frame_r <= 1'b0;
    end else begin
      frame_r <= 1'b0;
      if (!bus.en) begin
        an_r  <= '0;
        seg_r <= '1;
      end else begin
        case (state)
          ST_SCAN: begin
            an_r  <= an_cur;
            seg_r <= snap;
            if (cnt == DIV_LAST) begin
              cnt <= '0;
              // zero dead time: the next slot starts on the very next edge
              if (DEAD == 0) begin
                idx     <= next_idx;
                snap    <= slot_code;
                an_r    <= an_next;
                seg_r   <= slot_code;
                frame_r <= (next_idx == '0);
              end else begin
                state <= ST_DEAD;
                an_r  <= '0;
                seg_r <= '1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            an_r  <= '0;
            seg_r <= '1;
            if (DEAD == 0 || cnt == DEAD_LAST) begin
              state   <= ST_SCAN;
              cnt     <= '0;
              idx     <= next_idx;
              snap    <= slot_code;
              an_r    <= an_next;
              seg_r   <= slot_code;
              frame_r <= (next_idx == '0);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.an    = an_r;
  assign bus.seg   = seg_r;
  assign bus.frame = frame_r;
  assign bus.sum   = sum_r;
endmodule

// File: tb/tb_seg_scan_n.sv
// Scoreboard bench for seg_scan_n: slot starts are queued as expected
// {an,seg,frame} records and popped by per-instance monitors.
module tb_seg_scan_n;
  logic clk = 1'b0;
  logic rst0, rst1, rst2;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       frame;
  } slot_t;

  slot_t q0[$];
  slot_t q1[$];
  slot_t q2[$];

  seg_scan_n_if #(.NDIG(4)) b0();
  seg_scan_n_if #(.NDIG(2)) b1();
  seg_scan_n_if #(.NDIG(3)) b2();

  seg_scan_n #(.NDIG(4), .DIV(4), .DEAD(2)) u0 (.clk(clk), .reset(rst0), .bus(b0));
  seg_scan_n #(.NDIG(2), .DIV(4), .DEAD(2)) u1 (.clk(clk), .reset(rst1), .bus(b1));
  seg_scan_n #(.NDIG(3), .DIV(1), .DEAD(0)) u2 (.clk(clk), .reset(rst2), .bus(b2));

  function automatic slot_t mk(input logic [7:0] an, input logic [6:0] seg, input logic fr);
    mk = '{an: an, seg: seg, frame: fr};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input int id, input slot_t act);
    slot_t e;
    int    sz;
    sz = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL u%0d unexpected slot: got %0h expected none (t=%0t)", id, act, $time);
    end else begin
      if (id == 0)      e = q0.pop_front();
      else if (id == 1) e = q1.pop_front();
      else              e = q2.pop_front();
      check($sformatf("u%0d slot {an,seg,frame}", id), 32'(act), 32'(e));
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] prev0 = '0, prev1 = '0, prev2 = '0;

  always @(negedge clk) begin
    if (b0.an != '0 && {4'b0, b0.an} != prev0) sb_pop(0, mk({4'b0, b0.an}, b0.seg, b0.frame));
    prev0 <= {4'b0, b0.an};
  end
  always @(negedge clk) begin
    if (b1.an != '0 && {6'b0, b1.an} != prev1) sb_pop(1, mk({6'b0, b1.an}, b1.seg, b1.frame));
    prev1 <= {6'b0, b1.an};
  end
  always @(negedge clk) begin
    if (b2.an != '0 && {5'b0, b2.an} != prev2) sb_pop(2, mk({5'b0, b2.an}, b2.seg, b2.frame));
    prev2 <= {5'b0, b2.an};
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // expected {an,frame} per edge after reset release, DIV=4 DEAD=2 NDIG=2
  logic [2:0] t1 [1:14] = '{3'b000, 3'b011, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000,
                            3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 3'b011};

  initial begin
    int lit;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    b0.en = 1'b0; b0.lzb = 1'b0; b0.digits = 16'h1234;
    b1.en = 1'b1; b1.lzb = 1'b0; b1.digits = 8'h3A;
    b2.en = 1'b1; b2.lzb = 1'b0; b2.digits = 12'h321;
    wait_edges(2);

    // u1: reset state, then the 2-digit timing walk
    check("u1 reset {an,seg,frame,sum}", {b1.an, b1.seg, b1.frame, b1.sum},
          {2'b00, 7'h7F, 1'b0, 5'd0});
    q1.push_back(mk(8'h01, 7'h08, 1'b1));
    q1.push_back(mk(8'h02, 7'h06, 1'b0));
    q1.push_back(mk(8'h01, 7'h08, 1'b1));
    rst1 = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      wait_edges(1);
      check($sformatf("u1 edge%0d {an,frame}", e), {b1.an, b1.frame}, t1[e]);
      if (e == 1) check("u1 sum 3A", 32'(b1.sum), 32'd13);
    end
    rst1 = 1'b0;
    wait_edges(1);

    // u2: DEAD=0, DIV=1 rotates every edge
    for (int k = 0; k < 2; k++) begin
      q2.push_back(mk(8'h01, 7'h4F, 1'b1));
      q2.push_back(mk(8'h02, 7'h12, 1'b0));
      q2.push_back(mk(8'h04, 7'h06, 1'b0));
    end
    rst2 = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      wait_edges(1);
      check($sformatf("u2 edge%0d {an,frame}", e), {b2.an, b2.frame},
            {3'(1 << ((e - 1) % 3)), 1'((e - 1) % 3 == 0)});
    end
    rst2 = 1'b0;
    wait_edges(1);

    // u0: reset values, then sums with scanning frozen
    check("u0 reset {an,seg,frame,sum}", {b0.an, b0.seg, b0.frame, b0.sum},
          {4'b0, 7'h7F, 1'b0, 6'd0});
    rst0 = 1'b1;
    b0.digits = 16'h00F1; wait_edges(1);
    check("u0 sum 00F1", 32'(b0.sum), 32'd16);
    b0.digits = 16'hFFFF; wait_edges(1);
    check("u0 sum FFFF", 32'(b0.sum), 32'd60);
    b0.digits = 16'h1234; wait_edges(1);
    check("u0 sum 1234", 32'(b0.sum), 32'd10);
    check("u0 frozen an", 32'(b0.an), 32'd0);

    // u0: two frames of 0050, lzb on then off, then pause, digit change, reset
    b0.digits = 16'h0050; b0.lzb = 1'b1;
    q0.push_back(mk(8'h1, 7'h01, 1'b1));
    q0.push_back(mk(8'h2, 7'h24, 1'b0));
    q0.push_back(mk(8'h4, 7'h7F, 1'b0));
    q0.push_back(mk(8'h8, 7'h7F, 1'b0));
    q0.push_back(mk(8'h1, 7'h01, 1'b1));
    q0.push_back(mk(8'h2, 7'h24, 1'b0));
    q0.push_back(mk(8'h4, 7'h01, 1'b0));
    q0.push_back(mk(8'h8, 7'h01, 1'b0));
    q0.push_back(mk(8'h1, 7'h01, 1'b1));
    q0.push_back(mk(8'h1, 7'h01, 1'b0));
    q0.push_back(mk(8'h2, 7'h24, 1'b0));
    q0.push_back(mk(8'h4, 7'h01, 1'b0));
    q0.push_back(mk(8'h8, 7'h01, 1'b0));
    q0.push_back(mk(8'h1, 7'h01, 1'b1));
    q0.push_back(mk(8'h2, 7'h0F, 1'b0));
    q0.push_back(mk(8'h1, 7'h01, 1'b1));
    b0.en = 1'b1;
    wait_edges(22);
    b0.lzb = 1'b0;
    wait_edges(29);
    b0.en = 1'b0;
    for (int p = 0; p < 3; p++) begin
      wait_edges(1);
      check($sformatf("u0 paused%0d {an,seg,frame}", p), {b0.an, b0.seg, b0.frame},
            {4'b0, 7'h7F, 1'b0});
    end
    b0.en = 1'b1;
    lit = 0;
    for (int w = 0; w < 10; w++) begin
      wait_edges(1);
      if (b0.an == 4'b0001) lit++;
      else break;
    end
    check("u0 lit after resume", 32'(lit), 32'd2);
    wait_edges(3);
    b0.digits = 16'h0070;
    wait_edges(1);
    check("u0 snapshot hold a", {b0.an, b0.seg}, {4'b0010, 7'h24});
    wait_edges(1);
    check("u0 snapshot hold b", {b0.an, b0.seg}, {4'b0010, 7'h24});
    wait_edges(22);
    rst0 = 1'b0;
    wait_edges(1);
    check("u0 midslot reset {an,seg,frame,sum}", {b0.an, b0.seg, b0.frame, b0.sum},
          {4'b0, 7'h7F, 1'b0, 6'd0});
    rst0 = 1'b1;
    wait_edges(1);
    check("u0 restart edge1 an", 32'(b0.an), 32'd0);
    wait_edges(1);
    check("u0 restart edge2 {an,frame}", {b0.an, b0.frame}, {4'b0001, 1'b1});
    rst0 = 1'b0;
    wait_edges(2);

    check("u0 queue drained", 32'(q0.size()), 32'd0);
    check("u1 queue drained", 32'(q1.size()), 32'd0);
    check("u2 queue drained", 32'(q2.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seg_scan_n.md
SEG_SCAN_N -- requirements
Module: seg_scan_n

Interface
REQ-001 SHALL have parameter NDIG, default 4, number of multiplexed digits, legal range 2..8.
REQ-002 SHALL have parameter DIV, default 50000, clk cycles each digit is lit per slot, legal range >= 1.
REQ-003 SHALL have parameter DEAD, default 2, blank cycles between digit slots, legal range >= 0.
REQ-004 SHALL define SW = 4 + clog2(NDIG) as the sum width.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 en  in  1  scan enable; low blanks the display and freezes scanning.
REQ-008 lzb  in  1  leading-zero-blanking mode.
REQ-009 digits  in  4*NDIG  hex nibbles; digit i is bits [4i+3:4i]; digit 0 is least significant.
REQ-010 an  out  NDIG  one-hot digit select, active-high.
REQ-011 seg  out  7  segments {a,b,c,d,e,f,g} at bits [6:0], active-low.
REQ-012 sum  out  SW  unsigned sum of all NDIG digits.
REQ-013 frame  out  1  one-cycle pulse on each digit-0 slot start.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 FSM states: SCAN, DEAD; prescaler cnt; digit index idx (0..NDIG-1).
REQ-016 In SCAN, cnt SHALL count 0..DIV-1; at DIV-1 the block SHALL clear cnt, enter DEAD, and drive an=0 and seg=7'h7F from the next edge.
REQ-017 In DEAD, cnt SHALL count 0..DEAD-1; at DEAD-1 (or immediately on the first DEAD cycle when DEAD=0) it SHALL enter SCAN with idx+1, wrapping NDIG-1 -> 0.
REQ-018 On SCAN entry, an SHALL become one-hot at bit idx, and the nibble and blank decision for idx SHALL be snapshotted; changes to digits or lzb mid-slot SHALL NOT alter seg until the next slot.
REQ-019 The digit period SHALL be DIV+DEAD cycles; the frame period SHALL be NDIG*(DIV+DEAD) cycles.
REQ-020 frame SHALL be high for exactly the one cycle in which an[0] first asserts for a slot.
REQ-021 Segment codes (7-bit hex) SHALL be: 0:01 1:4F 2:12 3:06 4:4C 5:24 6:20 7:0F 8:00 9:04 A:08 b:60 C:31 d:42 E:30 F:38.
REQ-022 When lzb=1, digit i>0 SHALL be blanked (seg=7F, an still asserted) if digits i..NDIG-1 are all zero; digit 0 SHALL never be blanked.
REQ-023 While en=0, an SHALL be 0 and seg 7F from the next edge; cnt, idx, state and snapshot SHALL hold; frame SHALL be 0.
REQ-024 When en returns to 1, outputs SHALL restore from the next edge, and the slot SHALL resume with its remaining count (no restart).
REQ-025 sum SHALL be updated every cycle with 1-cycle latency, independent of en and of the FSM, and SHALL never overflow (width SW).

Reset
REQ-026 While reset=0: state=DEAD, idx=NDIG-1, cnt=0, an=0, seg=7F, sum=0, frame=0.
REQ-027 After release, the first slot SHALL be digit 0 with frame=1; an[0] SHALL assert at the edge ending the first DEAD interval (edge 1 if DEAD=0).
REQ-028 Reset asserted mid-slot SHALL return all state to REQ-026 values at the next edge, with no partial slot completion.

Verification
REQ-029 NDIG=2, DIV=4, DEAD=2, en=1, digits=8'h3A, release reset -> an=01, seg=08, frame=1 at edge 2; an=00 for 2 cycles after 4 lit cycles; then an=10, seg=06; an[0] again at cycle 14.
REQ-030 NDIG=4, digits=16'h00F1 -> sum=6'd16 one cycle later; digits=16'hFFFF -> sum=6'd60.
REQ-031 NDIG=4, lzb=1, digits=16'h0050 -> digits 3 and 2 seg=7F (an asserted), digit 1 seg=24, digit 0 seg=01; with lzb=0, all four digits lit.
REQ-032 en=0 for 3 cycles at cnt=2 of a DIV=4 slot -> an=0, seg=7F during; after en=1, the same digit is lit for exactly 2 more cycles.
REQ-033 Change digits mid-slot -> seg unchanged until the next slot of that digit; reset=0 mid-slot -> next edge an=0, seg=7F, sum=0; after release, restart per REQ-027.
REQ-034 DEAD=0, DIV=1, NDIG=3 -> an cycles 001, 010, 100 on consecutive edges, with frame every 3rd cycle.
